// File: rtl/cpu_pkg.sv
// Shared CPU types for the immediate encode/decode paths.
package cpu_pkg;

  typedef enum logic [1:0] {
    IMD_I = 2'b00,
    IMD_S,
    IMD_B,
    IMD_J
  } imd_src_t;

  localparam int IMD_W_I = 12;
  localparam int IMD_W_S = 12;
  localparam int IMD_W_B = 13;
  localparam int IMD_W_J = 21;

  typedef struct packed {
    logic [31:0] instr;
    logic        range_err;
    logic        align_err;
  } enc_entry_t;

endpackage

// File: rtl/cpu_imd_encode_unit_if.sv
// Request/response bundle for the immediate encode unit.
interface cpu_imd_encode_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [DATA_WIDTH-1:0] in_imd;
  logic [1:0]            in_imd_src;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic                  out_range_err;
  logic                  out_align_err;
  logic [7:0]            err_cnt;

  modport master (
    output in_valid, in_instr, in_imd, in_imd_src, out_ready,
    input  in_ready, out_valid, out_instr, out_range_err, out_align_err, err_cnt
  );

  modport slave (
    input  in_valid, in_instr, in_imd, in_imd_src, out_ready,
    output in_ready, out_valid, out_instr, out_range_err, out_align_err, err_cnt
  );
endinterface

// File: rtl/cpu_imd_field_packer.sv
// Combinational I/S/B/J immediate packer with range and alignment checks.
module cpu_imd_field_packer
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] imd,
  input  imd_src_t              src,
  output logic [31:0]           enc_instr,
  output logic                  range_err,
  output logic                  align_err
);

  int                    width;
  logic [DATA_WIDTH-1:0] hi;

  always_comb begin
    enc_instr = instr;
    width     = IMD_W_I;
    align_err = 1'b0;
    unique case (src)
      IMD_I: begin
        enc_instr[31:20] = imd[11:0];
      end
      IMD_S: begin
        enc_instr[31:25] = imd[11:5];
        enc_instr[11:7]  = imd[4:0];
        width            = IMD_W_S;
      end
      IMD_B: begin
        enc_instr[31]    = imd[12];
        enc_instr[7]     = imd[11];
        enc_instr[30:25] = imd[10:5];
        enc_instr[11:8]  = imd[4:1];
        width            = IMD_W_B;
        align_err        = imd[0];
      end
      IMD_J: begin
        enc_instr[31]    = imd[20];
        enc_instr[19:12] = imd[19:12];
        enc_instr[20]    = imd[11];
        enc_instr[30:21] = imd[10:1];
        width            = IMD_W_J;
        align_err        = imd[0];
      end
      default: ;
    endcase
    // Fits iff every bit from the format's sign bit upward equals that sign bit.
    hi        = $unsigned($signed(imd) >>> (width - 1));
    range_err = !((hi == '0) || (hi == '1));
  end

endmodule

// File: rtl/cpu_imd_encode_unit.sv
// Immediate encode unit: packer + main/skid output buffer + error counter.
// Optional build macro IMD_ENC_ERR_CNT_EN enables the saturating err_cnt.
module cpu_imd_encode_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  cpu_imd_encode_unit_if.slave    bus
);

  enc_entry_t new_e, main_q, main_d, skid_q, skid_d;
  logic       main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic       accept, drain;

  cpu_imd_field_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .instr     (bus.in_instr),
    .imd       (bus.in_imd),
    .src       (imd_src_t'(bus.in_imd_src)),
    .enc_instr (new_e.instr),
    .range_err (new_e.range_err),
    .align_err (new_e.align_err)
  );

  // Ready comes only from the skid flag so it never waits on out_ready.
  assign bus.in_ready = !skid_vld_q && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = main_vld_q && bus.out_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (drain) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = new_e;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (main_vld_q) begin
        skid_d     = new_e;
        skid_vld_d = 1'b1;
      end else begin
        main_d     = new_e;
        main_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign bus.out_valid     = main_vld_q;
  assign bus.out_instr     = main_q.instr;
  assign bus.out_range_err = main_q.range_err;
  assign bus.out_align_err = main_q.align_err;

`ifdef IMD_ENC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && (new_e.range_err || new_e.align_err) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'h00;
    else     err_cnt_q <= err_cnt_d;
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_cpu_imd_encode_unit.sv
// Randomized + directed bench for cpu_imd_encode_unit against a queue-based model.
module tb_cpu_imd_encode_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_imd_encode_unit_if #(.DATA_WIDTH(32)) bus ();

  cpu_imd_encode_unit #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] instr;
    logic        r;
    logic        a;
  } exp_t;

  exp_t q[$];
  int   cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int vis_cnt();
`ifdef IMD_ENC_ERR_CNT_EN
    return cnt;
`else
    return 0;
`endif
  endfunction

  // Reference: field placement by shifts/masks, range by signed interval.
  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] imd, input logic [1:0] src);
    exp_t   e;
    longint v, lim;
    int     n;
    logic [31:0] m;
    m = imd;
    case (src)
      2'd0: begin e.instr = (instr & 32'h000F_FFFF) | ((m & 32'hFFF) << 20); n = 12; end
      2'd1: begin
        e.instr = (instr & 32'h01FF_F07F) | (((m >> 5) & 32'h7F) << 25) | ((m & 32'h1F) << 7);
        n = 12;
      end
      2'd2: begin
        e.instr = (instr & 32'h01FF_F07F) | (((m >> 12) & 32'h1) << 31) | (((m >> 5) & 32'h3F) << 25)
                | (((m >> 1) & 32'hF) << 8) | (((m >> 11) & 32'h1) << 7);
        n = 13;
      end
      default: begin
        e.instr = (instr & 32'h0000_0FFF) | (((m >> 20) & 32'h1) << 31) | (((m >> 1) & 32'h3FF) << 21)
                | (((m >> 11) & 32'h1) << 20) | (((m >> 12) & 32'hFF) << 12);
        n = 21;
      end
    endcase
    v   = longint'($signed(imd));
    lim = longint'(1) << (n - 1);
    e.r = (v < -lim) || (v >= lim);
    e.a = (src >= 2'd2) && imd[0];
    return e;
  endfunction

  task automatic cyc();
    exp_t e;
    @(negedge clk);
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, (!rst && q.size() < 2)});
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      check("out_instr", bus.out_instr, q[0].instr);
      check("range_err", {31'd0, bus.out_range_err}, {31'd0, q[0].r});
      check("align_err", {31'd0, bus.out_align_err}, {31'd0, q[0].a});
    end
    check("err_cnt", {24'd0, bus.err_cnt}, vis_cnt());
    @(posedge clk);
    acc = 1'b0;
    if (rst) begin
      q.delete();
      cnt = 0;
    end else begin
      acc = bus.in_valid && (q.size() < 2);
      if (q.size() > 0 && bus.out_ready) e = q.pop_front();
      if (acc) begin
        e = model(bus.in_instr, bus.in_imd, bus.in_imd_src);
        q.push_back(e);
        if ((e.r || e.a) && cnt < 255) cnt++;
      end
    end
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] imd, input logic [1:0] src);
    bus.in_valid   = 1'b1;
    bus.in_instr   = instr;
    bus.in_imd     = imd;
    bus.in_imd_src = src;
  endtask

  task automatic dir(input logic [31:0] instr, input logic [31:0] imd, input logic [1:0] src,
                     input logic [31:0] x_instr, input logic x_r, input logic x_a, input int x_cnt);
    drive(instr, imd, src);
    bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    check("dir_instr", bus.out_instr, x_instr);
    check("dir_range", {31'd0, bus.out_range_err}, {31'd0, x_r});
    check("dir_align", {31'd0, bus.out_align_err}, {31'd0, x_a});
`ifdef IMD_ENC_ERR_CNT_EN
    check("dir_cnt", {24'd0, bus.err_cnt}, x_cnt);
`else
    check("dir_cnt", {24'd0, bus.err_cnt}, 0 * x_cnt);
`endif
    cyc();
  endtask

  function automatic logic [31:0] rnd_imd();
    logic [31:0] edges [12] = '{32'h7FF, 32'h800, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'hFFF, 32'h1000,
                                32'hFFFF_F000, 32'hFFFF_EFFE, 32'hF_FFFF, 32'h10_0000,
                                32'hFFF0_0000, 32'hFFEF_FFFE};
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 4095)) - 32'd2048;
      1:       return 32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000;
      2:       return $urandom;
      default: return edges[$urandom_range(0, 11)];
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_imd = '0; bus.in_imd_src = '0;
    bus.out_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_instr", bus.out_instr, 32'd0);
    check("rst_flags", {30'd0, bus.out_range_err, bus.out_align_err}, 32'd0);
    check("rst_cnt", {24'd0, bus.err_cnt}, 32'd0);
    cyc();

    dir(32'h0000_0013, 32'hFFFF_FFFF, 2'd0, 32'hFFF0_0013, 1'b0, 1'b0, 0);
    dir(32'h0000_2023, 32'h8,         2'd1, 32'h0000_2423, 1'b0, 1'b0, 0);
    dir(32'h0000_0063, 32'hFFFF_FFFC, 2'd2, 32'hFE00_0EE3, 1'b0, 1'b0, 0);
    dir(32'h0000_006F, 32'h800,       2'd3, 32'h0010_006F, 1'b0, 1'b0, 0);
    dir(32'h0000_0013, 32'h800,       2'd0, 32'h8000_0013, 1'b1, 1'b0, 1);
    dir(32'h0000_0063, 32'h3,         2'd2, 32'h0000_0163, 1'b0, 1'b1, 2);

    // Saturation: 300 back-to-back range errors.
    drive(32'h0000_0013, 32'h800, 2'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) cyc();
    bus.in_valid = 1'b0;
    cyc();
`ifdef IMD_ENC_ERR_CNT_EN
    check("sat_cnt", {24'd0, bus.err_cnt}, 32'd255);
`else
    check("sat_cnt", {24'd0, bus.err_cnt}, 32'd0);
`endif

    // Backpressure: three requests with out_ready low.
    bus.out_ready = 1'b0;
    drive(32'h0000_0013, 32'h1, 2'd0); cyc();
    drive(32'h0000_0013, 32'h2, 2'd0); cyc();
    check("bp_ready_drop", {31'd0, bus.in_ready}, 32'd0);
    drive(32'h0000_0013, 32'h3, 2'd0); cyc();
    check("bp_third_held", {31'd0, acc}, 32'd0);
    bus.out_ready = 1'b1;
    cyc();
    check("bp_first_drain", {31'd0, acc}, 32'd0);
    cyc();
    check("bp_third_acc", {31'd0, acc}, 32'd1);
    bus.in_valid = 1'b0;
    cyc(); cyc();

    // Reset with both entries full.
    bus.out_ready = 1'b0;
    drive(32'h0000_0063, 32'h5, 2'd2); cyc();
    drive(32'h0000_006F, 32'h7, 2'd3); cyc();
    bus.in_valid = 1'b0;
    rst = 1'b1; cyc();
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_cnt", {24'd0, bus.err_cnt}, 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive($urandom, rnd_imd(), 2'($urandom_range(0, 3)));
      else
        bus.in_valid = 1'b0;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_imd_encode_unit.md
# cpu_imd_encode_unit

Inverse of the CPU immediate sign-extend path. Takes a base instruction word, a signed immediate and an immediate format, and packs the immediate into the I/S/B/J bit fields. Flags values that do not fit the format or are misaligned. Sits between the boot/debug loader and instruction memory, and is used to relocate branch, jump and load/store offsets. Valid/ready on both sides, 1-cycle latency, full throughput, 2-entry output buffering.

## Interface
- DATA_WIDTH, 32, width of the immediate operand

- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready at clk edge
- in_instr  input  32  base instruction; immediate bits are overwritten, all other bits pass through
- in_imd  input  DATA_WIDTH  signed immediate
- in_imd_src  input  2  format: 0 I, 1 S, 2 B, 3 J
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_instr  output  32  encoded instruction
- out_range_err  output  1  immediate outside format range
- out_align_err  output  1  B/J immediate with bit 0 set
- err_cnt  output  8  saturating count of accepted requests with any error

## Operation
- Field packing; bits not listed are taken from in_instr:
  - I: [31:20]=imd[11:0]
  - S: [31:25]=imd[11:5], [11:7]=imd[4:0]
  - B: [31]=imd[12], [7]=imd[11], [30:25]=imd[10:5], [11:8]=imd[4:1]
  - J: [31]=imd[20], [19:12]=imd[19:12], [20]=imd[11], [30:21]=imd[10:1]
- Range check: imd[DATA_WIDTH-1:N-1] must be all equal, with N=12 for I/S, 13 for B, 21 for J.
- Align check: only B/J; error if imd[0]=1.
- On error the word is still packed (truncated, bit 0 dropped) and flags travel with it.
- Buffering: main register drives outputs, plus one skid register.
  - Accept while main is full and not draining -> entry goes to skid.
  - Main drained while skid is full -> skid moves to main the same edge.
  - Order is strictly preserved.
- in_ready = !skid_valid && !rst.
- err_cnt increments at accept time when (range_err || align_err) and holds at 255.

## Timing
- Reset (synchronous):
  - out_valid=0, skid empty, err_cnt=0.
  - out_instr and flags = 0.
  - in_ready=0 while rst is high, 1 the first cycle after.
- Reset mid-operation discards both entries; nothing is emitted.
- Latency: accept at edge N -> out_valid=1 after edge N.
- Throughput: one request per cycle with out_ready held high.
- out_instr and flags are stable while out_valid && !out_ready.
- Simultaneous accept and drain with skid empty: the new entry replaces main and out_valid stays 1.
- Simultaneous accept and drain with skid full: not possible, because in_ready=0.
- in_ready depends only on registered state, never on out_ready combinationally.

## Configuration
- IMD_ENC_ERR_CNT_EN
  - Defined: err_cnt counter implemented as above.
  - Undefined: counter logic removed and err_cnt tied to 8'h00.
  - out_range_err and out_align_err are present in both builds.

## Structure
- Shared package cpu_pkg holds:
  - enum imd_src_t (IMD_I=2'b00, IMD_S, IMD_B, IMD_J), also used by the decode side.
  - constants IMD_W_I=12, IMD_W_S=12, IMD_W_B=13, IMD_W_J=21.
- Sub-module cpu_imd_field_packer: combinational packing and range/align checks.
- The top level holds the main and skid registers, the handshake and the counter.

## Test plan
- I: in_instr 0x00000013, imd 0xFFFFFFFF -> out_instr 0xFFF00013, no flags, err_cnt 0.
- S: in_instr 0x00002023, imd 8 -> 0x00002423.
- B and J:
  - B: in_instr 0x00000063, imd 0xFFFFFFFC -> 0xFE000EE3.
  - J: in_instr 0x0000006F, imd 0x800 -> 0x0010006F.
- Errors:
  - I with imd 0x800 -> out_instr 0x80000013, out_range_err=1, err_cnt=1.
  - B with imd 3 -> out_align_err=1, err_cnt=2.
  - 300 erroneous requests -> err_cnt holds 255 (only when IMD_ENC_ERR_CNT_EN is defined; otherwise 0).
- Backpressure:
  - out_ready=0 with 3 back-to-back requests -> only 2 accepted and in_ready drops after the 2nd.
  - Raising out_ready then yields results in input order, with the 3rd accepted the cycle after the 1st drains.
- Reset with both entries full -> next cycle out_valid=0, err_cnt=0, no stale output after release.
